// File: rtl/seg_scan_driver.sv
// seg_scan_driver -- time-multiplexed seven-segment display driver.
//
// Scans NUM_DIGITS digits one at a time. Each digit gets GUARD_CYCLES
// all-off cycles (anti-ghosting gap) followed by SCAN_DIV driven cycles.
// Display data is double-buffered: load fills a pending buffer, which is
// promoted to the shadow (displayed) buffer only at the frame boundary,
// so a frame never shows a mix of old and new data.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zeros
// (digit k>0 goes dark when it and every higher nibble are 0 with no dp set).
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   value      hex nibbles, digit k = value[4k+3:4k], digit 0 rightmost
//   dp_in      decimal point per digit, 1 = lit
//   blank_in   force digit dark, 1 = blank
//   load       one-cycle strobe capturing value/dp_in/blank_in into pending
//   an         digit enables (pin level)
//   seg        segments {g,f,e,d,c,b,a} (pin level)
//   dp         decimal point (pin level)
//   frame_done one-cycle pulse on the last driven cycle of the last digit
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int CNT_MAX = (SCAN_DIV > GUARD_CYCLES) ? SCAN_DIV : GUARD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    // Polarity masks: internal levels are active-high, XOR gives pin level.
    localparam logic [NUM_DIGITS-1:0] AN_POL  = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [6:0]            SEG_POL = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic                  DP_POL  = (ACTIVE_LOW != 0);

    localparam logic [0:0] ST_GUARD = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [0:0]              state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [IW-1:0]           idx, idx_n;
    logic                    fd_n;

    logic [4*NUM_DIGITS-1:0] shadow_val, pending_val;
    logic [NUM_DIGITS-1:0]   shadow_dp, pending_dp;
    logic [NUM_DIGITS-1:0]   shadow_blank, pending_blank;
    logic                    pending_valid;

    logic [NUM_DIGITS-1:0]   blank_eff;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [6:0]              seg_n;
    logic                    dp_n;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0:    decode = 7'b0111111;
            4'h1:    decode = 7'b0000110;
            4'h2:    decode = 7'b1011011;
            4'h3:    decode = 7'b1001111;
            4'h4:    decode = 7'b1100110;
            4'h5:    decode = 7'b1101101;
            4'h6:    decode = 7'b1111101;
            4'h7:    decode = 7'b0000111;
            4'h8:    decode = 7'b1111111;
            4'h9:    decode = 7'b1101111;
            4'hA:    decode = 7'b1110111;
            4'hB:    decode = 7'b1111100;
            4'hC:    decode = 7'b0111001;
            4'hD:    decode = 7'b1011110;
            4'hE:    decode = 7'b1111001;
            default: decode = 7'b1110001;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  zero_run;

    // Walk from the top digit down; the run of all-zero, no-dp digits is dark.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
            zero_run = zero_run
                     && (shadow_val[4*(NUM_DIGITS-1-k) +: 4] == 4'h0)
                     && !shadow_dp[NUM_DIGITS-1-k];
            lz_blank[NUM_DIGITS-1-k] = zero_run;
        end
    end

    assign blank_eff = shadow_blank | lz_blank;
`else
    assign blank_eff = shadow_blank;
`endif

    // Next-state and next-output logic. Outputs are registered from the
    // next state so the pins line up cycle-for-cycle with the FSM phase.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        if (state == ST_GUARD) begin
            if (cnt == GUARD_LAST) begin
                state_n = ST_DRIVE;
                cnt_n   = '0;
            end
        end else if (cnt == DRIVE_LAST) begin
            state_n = ST_GUARD;
            cnt_n   = '0;
            idx_n   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end

        fd_n  = (state_n == ST_DRIVE) && (idx_n == IDX_LAST) && (cnt_n == DRIVE_LAST);

        an_n  = '0;
        seg_n = '0;
        dp_n  = 1'b0;
        if (state_n == ST_DRIVE) begin
            an_n[idx_n] = 1'b1;
            if (!blank_eff[idx_n]) begin
                seg_n = decode(shadow_val[4*idx_n +: 4]);
                dp_n  = shadow_dp[idx_n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_GUARD;
            cnt           <= '0;
            idx           <= '0;
            shadow_val    <= '0;
            shadow_dp     <= '0;
            shadow_blank  <= '0;
            pending_val   <= '0;
            pending_dp    <= '0;
            pending_blank <= '0;
            pending_valid <= 1'b0;
            an            <= AN_POL;
            seg           <= SEG_POL;
            dp            <= DP_POL;
            frame_done    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            an         <= an_n ^ AN_POL;
            seg        <= seg_n ^ SEG_POL;
            dp         <= dp_n ^ DP_POL;
            frame_done <= fd_n;

            // Shadow only moves at the frame boundary; a load landing on
            // that same cycle bypasses pending and goes straight to shadow.
            if (load && frame_done) begin
                shadow_val    <= value;
                shadow_dp     <= dp_in;
                shadow_blank  <= blank_in;
                pending_valid <= 1'b0;
            end else begin
                if (frame_done && pending_valid) begin
                    shadow_val    <= pending_val;
                    shadow_dp     <= pending_dp;
                    shadow_blank  <= pending_blank;
                    pending_valid <= 1'b0;
                end
                if (load) begin
                    pending_val   <= value;
                    pending_dp    <= dp_in;
                    pending_blank <= blank_in;
                    pending_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver -- directed bench for seg_scan_driver
// (NUM_DIGITS=4, SCAN_DIV=4, GUARD_CYCLES=2, ACTIVE_LOW=1: 24-cycle frame).
module tb_seg_scan_driver;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seg_scan_driver #(
        .NUM_DIGITS  (4),
        .SCAN_DIV    (4),
        .GUARD_CYCLES(2),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .dp_in     (dp_in),
        .blank_in  (blank_in),
        .load      (load),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: phase counter since reset plus both buffers.
    int          c = 0;
    bit          armed = 0;
    logic [15:0] sh_val = '0, pd_val = '0;
    logic [3:0]  sh_dp = '0, sh_bl = '0, pd_dp = '0, pd_bl = '0;
    logic        pv = 1'b0;

    function automatic logic [6:0] ref_dec(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
              7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
              7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
              7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
        return t[n];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (phase %0d, t=%0t)", name, act, exp, c % 24, $time);
        end
    endtask

    task automatic check_model();
        int         p, d, q;
        logic [3:0] ea, bl;
        logic [6:0] es;
        logic       ed;
        p  = c % 24;
        d  = p / 6;
        q  = p % 6;
        ea = 4'hF;
        es = 7'h7F;
        ed = 1'b1;
        bl = sh_bl;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            bit run;
            run = 1;
            for (int k = 3; k >= 1; k--) begin
                run = run && (sh_val[4*k +: 4] == 4'h0) && !sh_dp[k];
                if (run) bl[k] = 1'b1;
            end
        end
`endif
        if (q >= 2) begin
            ea[d] = 1'b0;
            if (!bl[d]) begin
                es = ~ref_dec(sh_val[4*d +: 4]);
                ed = ~sh_dp[d];
            end
        end
        chk("scan", {19'd0, an, seg, dp, frame_done}, {19'd0, ea, es, ed, (p == 23)});
    endtask

    // Advance one clock: apply the model's edge effects for the inputs
    // present this cycle, then sample at the falling edge.
    task automatic tick();
        logic r;
        r = reset;
        if (!r && armed) begin
            if (load) begin
                if (c % 24 == 23) begin
                    sh_val = value; sh_dp = dp_in; sh_bl = blank_in; pv = 1'b0;
                end else begin
                    pd_val = value; pd_dp = dp_in; pd_bl = blank_in; pv = 1'b1;
                end
            end else if (c % 24 == 23 && pv) begin
                sh_val = pd_val; sh_dp = pd_dp; sh_bl = pd_bl; pv = 1'b0;
            end
        end
        @(negedge clk);
        if (r) begin
            c = 0; armed = 1;
            sh_val = '0; sh_dp = '0; sh_bl = '0;
            pd_val = '0; pd_dp = '0; pd_bl = '0; pv = 1'b0;
        end else begin
            c++;
        end
        if (armed) check_model();
    endtask

    task automatic goto(input int p);
        while (c % 24 != p) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value = v; dp_in = d; blank_in = b; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    typedef struct {
        logic [15:0]     v;
        logic [3:0]      d;
        logic [3:0]      b;
        logic [3:0][6:0] seg_pin;   // expected seg pins, index = digit
        logic [3:0]      dp_pin;    // expected dp pins, bit = digit
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fd_count;
        int fd_first;

        vecs[0] = '{16'h1A3F, 4'b0100, 4'b0000, {7'h79, 7'h08, 7'h30, 7'h0E}, 4'b1011};
        vecs[1] = '{16'h1234, 4'b0000, 4'b0010, {7'h79, 7'h24, 7'h7F, 7'h19}, 4'b1111};
        vecs[2] = '{16'h8888, 4'b1111, 4'b0000, {7'h00, 7'h00, 7'h00, 7'h00}, 4'b0000};
        vecs[3] = '{16'h5E6B, 4'b0001, 4'b0000, {7'h12, 7'h06, 7'h02, 7'h03}, 4'b1110};
        vecs[4] = '{16'hC7D9, 4'b1000, 4'b1000, {7'h7F, 7'h78, 7'h21, 7'h10}, 4'b1111};

        reset = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_in = '0;

        // Reset and release timing
        tick();
        tick();
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;
        chk("guard0_an", {28'd0, an}, 32'hF);
        tick();
        chk("guard1_an", {28'd0, an}, 32'hF);
        tick();
        chk("drive0_an", {28'd0, an}, 32'hE);
        chk("drive0_seg", {25'd0, seg}, 32'h40);
        fd_count = 0;
        fd_first = -1;
        for (int i = 0; i < 48; i++) begin
            tick();
            if (frame_done) begin
                fd_count++;
                if (fd_first < 0) fd_first = c;
            end
        end
        chk("fd_count", fd_count, 32'd2);
        chk("fd_first", fd_first, 32'd23);

        // Table of loads: each shown from the next frame onward
        for (int i = 0; i < 5; i++) begin
            goto(10);
            do_load(vecs[i].v, vecs[i].d, vecs[i].b);
            for (int dg = 0; dg < 4; dg++) begin
                goto(dg * 6 + 3);
                chk($sformatf("vec%0d_an%0d", i, dg), {28'd0, an}, {28'd0, ~(4'b0001 << dg)});
                chk($sformatf("vec%0d_seg%0d", i, dg), {25'd0, seg}, {25'd0, vecs[i].seg_pin[dg]});
                chk($sformatf("vec%0d_dp%0d", i, dg), {31'd0, dp}, {31'd0, vecs[i].dp_pin[dg]});
            end
        end

        // Mid-frame load: current frame keeps C7D9, next frame shows 8888
        goto(8);
        do_load(16'h8888, 4'b0000, 4'b0000);
        goto(9);
        chk("midload_old_d1", {25'd0, seg}, 32'h21);
        goto(15);
        chk("midload_old_d2", {25'd0, seg}, 32'h78);
        goto(3);
        chk("midload_new_d0", {25'd0, seg}, 32'h00);
        chk("midload_new_dp0", {31'd0, dp}, 32'd1);

        // Load on the frame_done cycle: visible in the very next frame
        goto(23);
        chk("fd_cycle", {31'd0, frame_done}, 32'd1);
        do_load(16'h1234, 4'b0000, 4'b0000);
        goto(3);
        chk("fdload_d0", {25'd0, seg}, 32'h19);

        // Two loads in one frame: the last one wins
        goto(5);
        do_load(16'h1111, 4'b0000, 4'b0000);
        goto(12);
        do_load(16'h2222, 4'b0000, 4'b0000);
        goto(3);
        chk("lastwins_d0", {25'd0, seg}, 32'h24);
        goto(9);
        chk("lastwins_d1", {25'd0, seg}, 32'h24);

        // Reset during DRIVE of digit 2; load during reset is ignored
        goto(15);
        chk("pre_rst_an", {28'd0, an}, 32'hB);
        reset = 1'b1;
        value = 16'hFFFF; dp_in = 4'hF; blank_in = 4'h0; load = 1'b1;
        tick();
        chk("midrst_an", {28'd0, an}, 32'hF);
        chk("midrst_fd", {31'd0, frame_done}, 32'd0);
        tick();
        reset = 1'b0; load = 1'b0;
        tick();
        tick();
        chk("rst_restart_an", {28'd0, an}, 32'hE);
        chk("rst_restart_seg", {25'd0, seg}, 32'h40);
        goto(23);
        goto(3);
        chk("rst_noload_seg", {25'd0, seg}, 32'h40);
        chk("rst_noload_dp", {31'd0, dp}, 32'd1);

`ifdef LEADING_ZERO_BLANK_EN
        // Leading-zero suppression
        goto(10);
        do_load(16'h0050, 4'b0000, 4'b0000);
        goto(3);
        chk("lzb_d0", {25'd0, seg}, 32'h40);
        goto(9);
        chk("lzb_d1", {25'd0, seg}, 32'h12);
        goto(15);
        chk("lzb_d2", {25'd0, seg}, 32'h7F);
        chk("lzb_d2_an", {28'd0, an}, 32'hB);
        goto(21);
        chk("lzb_d3", {25'd0, seg}, 32'h7F);
        goto(10);
        do_load(16'h0000, 4'b0000, 4'b0000);
        goto(3);
        chk("lzb0_d0", {25'd0, seg}, 32'h40);
        goto(9);
        chk("lzb0_d1", {25'd0, seg}, 32'h7F);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
